// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier: shift-add of |a| by |b|, one partial product per cycle.
// Optional macro SM_MULT_EARLY_TERM_EN lets BUSY end as soon as the remaining multiplier bits are zero.
module sm_seq_multiplier #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a_sign,
    output logic              b_sign,
    output logic [2*DW-1:0]   unsigned_product
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [2*DW-1:0]   ma;
    logic [2*DW-1:0]   acc;
    logic [DW-1:0]     mb;
    logic [DW-1:0]     mb_shift;
    logic [DW-1:0]     mag_a;
    logic [DW-1:0]     mag_b;
    logic [CW-1:0]     cnt;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              last_iter;

    // The most negative value negates to itself, which is the correct unsigned magnitude.
    assign mag_a    = a[DW-1] ? (~a + {{(DW-1){1'b0}}, 1'b1}) : a;
    assign mag_b    = b[DW-1] ? (~b + {{(DW-1){1'b0}}, 1'b1}) : b;
    assign mb_shift = mb >> 1;

`ifdef SM_MULT_EARLY_TERM_EN
    assign last_iter = (cnt == CW'(DW - 1)) || (mb_shift == '0);
`else
    assign last_iter = (cnt == CW'(DW - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a_q <= a[DW-1];
                        sign_b_q <= b[DW-1];
                        ma       <= {{DW{1'b0}}, mag_a};
                        mb       <= mag_b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mb[0]) begin
                        acc <= acc + ma;
                    end
                    ma  <= ma << 1;
                    mb  <= mb_shift;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs depend only on the state register (and reset), never on in_valid/out_ready.
    assign in_ready         = (state == IDLE) && !rst;
    assign out_valid        = (state == DONE);
    assign unsigned_product = acc;
    assign a_sign           = sign_a_q;
    assign b_sign           = sign_b_q;

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Self-checking bench for sm_seq_multiplier: vector table, stall/hold-off and mid-run reset sequences, random pairs.
// Latency expectations follow SM_MULT_EARLY_TERM_EN the same way the design does.
module tb_sm_seq_multiplier;

    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic              a_sign;
    logic              b_sign;
    logic [2*DW-1:0]   unsigned_product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_seq_multiplier #(.DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .a_sign           (a_sign),
        .b_sign           (b_sign),
        .unsigned_product (unsigned_product)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        int         prod;
        bit         as;
        bit         bs;
        int         lat_full;
        int         lat_et;
        int         stall;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    function automatic int pickLat(input int lat_full, input int lat_et);
`ifdef SM_MULT_EARLY_TERM_EN
        return lat_et;
`else
        return lat_full;
`endif
    endfunction

    // Independent reference latency for the random pairs.
    function automatic int modelLat(input logic [7:0] vb);
`ifdef SM_MULT_EARLY_TERM_EN
        int m;
        int n;
        m = $signed(vb);
        if (m < 0) m = -m;
        n = 0;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        return (n == 0) ? 1 : n;
`else
        return DW;
`endif
    endfunction

    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input int stall,
                                 input int ep, input bit eas, input bit ebs, input int elat,
                                 input string tag);
        int n;
        int lat;
        @(negedge clk);
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " accept"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, lat, elat);
        checkOutput({tag, " product"}, int'(unsigned_product), ep);
        checkOutput({tag, " a_sign"}, int'(a_sign), int'(eas));
        checkOutput({tag, " b_sign"}, int'(b_sign), int'(ebs));
        checkOutput({tag, " in_ready_done"}, int'(in_ready), 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " stall out_valid"}, int'(out_valid), 1);
            checkOutput({tag, " stall product"}, int'(unsigned_product), ep);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " release out_valid"}, int'(out_valid), 0);
        checkOutput({tag, " release in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        bit spurious;
        logic [7:0] ra;
        logic [7:0] rb;
        int ma;
        int mb;

        vecs[0] = '{8'd3,    8'd5,    15,    1'b0, 1'b0, 8, 3, 0};
        vecs[1] = '{8'h80,   8'h80,   16384, 1'b1, 1'b1, 8, 8, 1};
        vecs[2] = '{8'hF9,   8'd0,    0,     1'b1, 1'b0, 8, 1, 0};
        vecs[3] = '{8'd127,  8'hFF,   127,   1'b0, 1'b1, 8, 1, 2};
        vecs[4] = '{8'hFF,   8'hFF,   1,     1'b1, 1'b1, 8, 1, 0};
        vecs[5] = '{8'd0,    8'h80,   0,     1'b0, 1'b1, 8, 8, 0};
        vecs[6] = '{8'd12,   8'hF6,   120,   1'b0, 1'b1, 8, 4, 3};
        vecs[7] = '{8'h9C,   8'd50,   5000,  1'b1, 1'b0, 8, 6, 0};
        vecs[8] = '{8'd127,  8'd127,  16129, 1'b0, 1'b0, 8, 7, 1};
        vecs[9] = '{8'h81,   8'd1,    127,   1'b1, 1'b0, 8, 1, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", int'(in_ready), 0);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset product", int'(unsigned_product), 0);
        checkOutput("reset a_sign", int'(a_sign), 0);
        checkOutput("reset b_sign", int'(b_sign), 0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].stall, vecs[i].prod,
                          vecs[i].as, vecs[i].bs, pickLat(vecs[i].lat_full, vecs[i].lat_et),
                          $sformatf("vec%0d", i));
        end

        // Stalled result with a second pair already waiting on in_valid.
        @(negedge clk);
        a         = 8'hFA;
        b         = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 8'd5;
        b = 8'd9;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("hold latency", lat, pickLat(8, 3));
        for (int s = 0; s < 5; s++) begin
            checkOutput("hold in_ready", int'(in_ready), 0);
            checkOutput("hold out_valid", int'(out_valid), 1);
            checkOutput("hold product", int'(unsigned_product), 42);
            checkOutput("hold a_sign", int'(a_sign), 1);
            checkOutput("hold b_sign", int'(b_sign), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("hold release in_ready", int'(in_ready), 1);
        checkOutput("hold release out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("second accepted", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("second latency", lat, pickLat(8, 4));
        checkOutput("second product", int'(unsigned_product), 45);
        checkOutput("second a_sign", int'(a_sign), 0);
        checkOutput("second b_sign", int'(b_sign), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a BUSY run.
        @(negedge clk);
        a        = 8'd100;
        b        = 8'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset out_valid", int'(out_valid), 0);
        checkOutput("midreset product", int'(unsigned_product), 0);
        checkOutput("midreset a_sign", int'(a_sign), 0);
        checkOutput("midreset b_sign", int'(b_sign), 0);
        #1;
        checkOutput("midreset in_ready", int'(in_ready), 1);
        spurious = 1'b0;
        for (int s = 0; s < 12; s++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious = 1'b1;
        end
        checkOutput("midreset no spurious", int'(spurious), 0);
        applyStimulus(8'd2, 8'hFD, 0, 6, 1'b0, 1'b1, pickLat(8, 2), "after-reset");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ma = $signed(ra);
            mb = $signed(rb);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
            applyStimulus(ra, rb, int'($urandom_range(0, 3)), ma * mb, ra[7], rb[7],
                          modelLat(rb), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
